// File: rtl/mips_pkg.sv
// mips_pkg: shared state encodings and constants for the execute-stage multi-cycle units.
package mips_pkg;
  localparam int XLEN = 32;
  localparam int DIV_STEPS = 32;
  localparam int MUL_STEPS = 32;
  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} div_state_t;
  typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on {rem, quo}.
module div_step
  import mips_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  // One guard bit above the remainder keeps the borrow unambiguous.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_diff  = w_shift - {2'b00, i_div};
  assign o_rem   = w_diff[WIDTH+1] ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
  assign o_quo   = {i_quo[WIDTH-2:0], ~w_diff[WIDTH+1]};
endmodule

// File: rtl/divider.sv
// divider: iterative restoring DIV/DIVU writing quotient to lo and remainder to hi.
module divider
  import mips_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             DivE,
  input  logic             DivSgn,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             completed,
  output logic             busy,
  output logic             divzero
);
  localparam int CW = $clog2(DIV_STEPS);
  div_state_t       r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_sgn, r_neg_a, r_neg_b;
  logic [WIDTH-1:0] r_quo, r_div, r_dvd;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH:0]   w_rem;
  logic [WIDTH-1:0] w_quo, w_abs_a, w_abs_b, w_q_fix, w_r_fix;
  logic             w_zero;
  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem(r_rem),
    .i_quo(r_quo),
    .i_div(r_div),
    .o_rem(w_rem),
    .o_quo(w_quo)
  );
  assign w_abs_a = (DivSgn && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
  assign w_abs_b = (DivSgn && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
  assign w_q_fix = (r_sgn && (r_neg_a ^ r_neg_b)) ? -r_quo : r_quo;
  assign w_r_fix = (r_sgn && r_neg_a) ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
  assign w_zero  = (r_div == '0);
  assign busy    = (r_state == RUN) || (r_state == FIXUP);
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (DivE ? RUN : IDLE)
           : !DivE             ? IDLE
           : (r_state == RUN)  ? ((r_cnt == CW'(DIV_STEPS - 1)) ? FIXUP : RUN)
           :                     DONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_sgn     <= 1'b0;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_quo     <= '0;
      r_div     <= '0;
      r_dvd     <= '0;
      r_rem     <= '0;
      hi        <= '0;
      lo        <= '0;
      completed <= 1'b0;
      divzero   <= 1'b0;
    end else begin
      if (r_state == IDLE && DivE) begin
        r_sgn   <= DivSgn;
        r_neg_a <= DivSgn & SrcAE[WIDTH-1];
        r_neg_b <= DivSgn & SrcBE[WIDTH-1];
        r_quo   <= w_abs_a;
        r_div   <= w_abs_b;
        r_dvd   <= SrcAE;
        r_rem   <= '0;
        r_cnt   <= '0;
      end
      if (r_state == RUN && DivE) begin
        r_rem <= w_rem;
        r_quo <= w_quo;
        r_cnt <= r_cnt + 1'b1;
      end
      // A zero divisor overrides the sign fix-up with the architected result.
      if (r_state == FIXUP && DivE) begin
        lo        <= w_zero ? '1 : w_q_fix;
        hi        <= w_zero ? r_dvd : w_r_fix;
        completed <= 1'b1;
        divzero   <= w_zero;
      end
      if (r_state == DONE && !DivE) completed <= 1'b0;
    end
  end
endmodule

// File: tb/tb_divider.sv
// tb_divider: scoreboard-driven bench for the iterative divider.
module tb_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] SrcAE = '0, SrcBE = '0;
  logic        DivE = 1'b0, DivSgn = 1'b0;
  logic [31:0] hi, lo;
  logic        completed, busy, divzero;
  typedef struct packed {logic [31:0] lo; logic [31:0] hi; logic dz;} exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  divider dut (
    .clk(clk), .rst(rst), .SrcAE(SrcAE), .SrcBE(SrcBE), .DivE(DivE), .DivSgn(DivSgn),
    .hi(hi), .lo(lo), .completed(completed), .busy(busy), .divzero(divzero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    e.dz = 1'b0;
    if (b == 32'd0) begin
      e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000; e.hi = 32'd0;
    end else if (s) begin
      e.lo = 32'($signed(a) / $signed(b));
      e.hi = 32'($signed(a) % $signed(b));
    end else begin
      e.lo = a / b; e.hi = a % b;
    end
    return e;
  endfunction

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s, input string nm);
    int n;
    logic early;
    logic [31:0] plo, phi;
    exp_t e;
    @(negedge clk);
    SrcAE = a; SrcBE = b; DivSgn = s; DivE = 1'b1;
    sb.push_back(model(a, b, s));
    plo = lo; phi = hi; early = 1'b0; n = 0;
    do begin
      @(posedge clk); n++; #1;
      if (n == 1) begin
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy: got %b want 1", nm, busy); end
        SrcAE = $urandom; SrcBE = $urandom; DivSgn = ~s;
      end
      if (!completed && (lo !== plo || hi !== phi)) early = 1'b1;
    end while (!completed && n < 100);
    n_chk++;
    if (n !== 34) begin n_fail++; $display("FAIL %s latency: got %0d edges want 34", nm, n); end
    n_chk++;
    if (early) begin n_fail++; $display("FAIL %s early_update: hi/lo changed before completed, want unchanged %h/%h", nm, phi, plo); end
    e = sb.pop_front();
    n_chk++;
    if (lo !== e.lo) begin n_fail++; $display("FAIL %s lo: got %h want %h", nm, lo, e.lo); end
    n_chk++;
    if (hi !== e.hi) begin n_fail++; $display("FAIL %s hi: got %h want %h", nm, hi, e.hi); end
    n_chk++;
    if (divzero !== e.dz) begin n_fail++; $display("FAIL %s divzero: got %b want %b", nm, divzero, e.dz); end
    @(posedge clk); #1;
    n_chk++;
    if (completed !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s hold: completed=%b busy=%b want 1/0", nm, completed, busy);
    end
    @(negedge clk); DivE = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (completed !== 1'b0 || lo !== e.lo || hi !== e.hi) begin
      n_fail++; $display("FAIL %s release: completed=%b lo=%h hi=%h want 0 %h %h", nm, completed, lo, hi, e.lo, e.hi);
    end
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if ({hi, lo, completed, busy, divzero} !== '0) begin
      n_fail++; $display("FAIL reset: hi=%h lo=%h c=%b b=%b dz=%b want all 0", hi, lo, completed, busy, divzero);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_divu();
    do_div(32'd100, 32'd7, 1'b0, "divu_100_7");
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1");
    do_div(32'hDEAD_BEEF, 32'h0001_2345, 1'b0, "divu_rand");
    do_div(32'd3, 32'hFFFF_FFFF, 1'b0, "divu_small");
  endtask

  task automatic test_div_signed();
    do_div(-32'd100, 32'd7, 1'b1, "div_m100_7");
    do_div(32'd100, -32'd7, 1'b1, "div_100_m7");
    do_div(-32'd100, -32'd7, 1'b1, "div_m100_m7");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
  endtask

  task automatic test_divzero();
    do_div(32'd5, 32'd0, 1'b0, "divu_5_0");
    do_div(-32'd5, 32'd0, 1'b1, "div_m5_0");
    do_div(32'd12, 32'd4, 1'b1, "div_after_zero");
  endtask

  task automatic test_abort();
    logic [31:0] plo, phi;
    logic seen;
    plo = lo; phi = hi; seen = 1'b0;
    @(negedge clk);
    SrcAE = 32'd9; SrcBE = 32'd3; DivSgn = 1'b0; DivE = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (completed) seen = 1'b1; end
    @(negedge clk); DivE = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (completed) seen = 1'b1; end
    n_chk++;
    if (seen || lo !== plo || hi !== phi) begin
      n_fail++; $display("FAIL abort: completed_seen=%b lo=%h hi=%h want 0 %h %h", seen, lo, hi, plo, phi);
    end
    do_div(32'd20, 32'd6, 1'b0, "after_abort");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    SrcAE = 32'd12345; SrcBE = 32'd7; DivSgn = 1'b0; DivE = 1'b1;
    repeat (15) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({hi, lo, completed, busy, divzero} !== '0) begin
      n_fail++; $display("FAIL reset_mid: hi=%h lo=%h c=%b b=%b dz=%b want all 0", hi, lo, completed, busy, divzero);
    end
    @(negedge clk); DivE = 1'b0; rst = 1'b1;
    do_div(32'd8, 32'd2, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_divzero();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
